mbs_seq: RTL

Upstream sequencer and result collector for the 8-bit shift-and-add multiplier (mbs).
- Accepts an operand pair over a valid/ready handshake and drives mbs start/operands: one load cycle, then one cycle per multiplier bit.
- Captures mbs produto before mbs clears it, then presents the product over a valid/ready handshake.
- mbs is a sibling instance, wired to this block at the parent level.

---
 rtl/mbs_pkg.sv | 22 ++
 rtl/mbs.sv | 50 +++++
 rtl/mbs_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mbs_pkg.sv
// -----------------------------------------------------------------------------
// mbs_pkg
// Shared constants and the sequencer state type for the 8-bit shift-and-add
// multiplier (mbs) and its upstream sequencer (mbs_seq).
//   OP_W            : operand width
//   PROD_W          : product width
//   mbs_seq_state_t : sequencer FSM states
// -----------------------------------------------------------------------------
package mbs_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    DONE
  } mbs_seq_state_t;

endpackage

// File: rtl/mbs.sv
// -----------------------------------------------------------------------------
// mbs
// 8-bit shift-and-add multiplier. start = 0 loads the operands and clears the
// accumulator; each cycle with start = 1 consumes one multiplier bit (LSB
// first). The product is complete after OP_W iterating cycles.
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          0 = load, 1 = iterate
//   multiplicando  operand A
//   multiplicador  operand B
//   produto        registered accumulator / product
// -----------------------------------------------------------------------------
module mbs #(
  parameter int OP_W   = mbs_pkg::OP_W,
  parameter int PROD_W = 2 * OP_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [OP_W-1:0]   multiplicando,
  input  logic [OP_W-1:0]   multiplicador,
  output logic [PROD_W-1:0] produto
);

  logic [PROD_W-1:0] mcand_q;
  logic [OP_W-1:0]   mplier_q;
  logic [PROD_W-1:0] acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (!start) begin
      mcand_q  <= PROD_W'(multiplicando);
      mplier_q <= multiplicador;
      acc_q    <= '0;
    end else begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign produto = acc_q;

endmodule

// File: rtl/mbs_seq.sv
// -----------------------------------------------------------------------------
// mbs_seq
// Upstream sequencer and result collector for the mbs multiplier. Accepts an
// operand pair (valid/ready), drives mbs through one load cycle and the
// iterate cycles, captures the finished product and presents it (valid/ready).
// Ports:
//   clock, reset_n                       clock / async active-low reset
//   in_valid, in_ready                   operand handshake
//   in_multiplicando, in_multiplicador   operands A, B
//   mbs_start                            to mbs (0 = load, 1 = iterate)
//   mbs_multiplicando, mbs_multiplicador latched operands to mbs
//   mbs_produto                          product from mbs
//   out_valid, out_ready, out_produto    product handshake
//   busy                                 FSM not in IDLE
// Optional feature macro: MBS_SEQ_EARLY_EXIT_EN -- stop iterating once the
// remaining multiplier bits are all zero (multiplier 0 skips RUN entirely).
// -----------------------------------------------------------------------------
module mbs_seq #(
  parameter int OP_W   = mbs_pkg::OP_W,
  parameter int PROD_W = 2 * OP_W,
  parameter int CNT_W  = $clog2(OP_W + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_multiplicando,
  input  logic [OP_W-1:0]   in_multiplicador,
  output logic              mbs_start,
  output logic [OP_W-1:0]   mbs_multiplicando,
  output logic [OP_W-1:0]   mbs_multiplicador,
  input  logic [PROD_W-1:0] mbs_produto,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_produto,
  output logic              busy
);

  import mbs_pkg::*;

  mbs_seq_state_t    state_q, state_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              out_valid_q, out_valid_d;
`ifdef MBS_SEQ_EARLY_EXIT_EN
  logic [OP_W-1:0]   shadow_q, shadow_d;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef MBS_SEQ_EARLY_EXIT_EN
      shadow_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
`ifdef MBS_SEQ_EARLY_EXIT_EN
      shadow_q    <= shadow_d;
`endif
    end
  end

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
`ifdef MBS_SEQ_EARLY_EXIT_EN
    shadow_d    = shadow_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = in_multiplicando;
          op_b_d  = in_multiplicador;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d = '0;
`ifdef MBS_SEQ_EARLY_EXIT_EN
        shadow_d = op_b_q;
        state_d  = (op_b_q == '0) ? CAPTURE : RUN;
`else
        state_d  = RUN;
`endif
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MBS_SEQ_EARLY_EXIT_EN
        // The bit consumed this cycle is shadow_q[0]; once everything above
        // it is zero the accumulator can no longer change.
        shadow_d = shadow_q >> 1;
        if (shadow_q[OP_W-1:1] == '0 || cnt_q == CNT_W'(OP_W - 1)) state_d = CAPTURE;
`else
        if (cnt_q == CNT_W'(OP_W - 1)) state_d = CAPTURE;
`endif
      end
      CAPTURE: begin
        // mbs_produto is a register, so this still samples the finished
        // product even though mbs clears on this same edge (start = 0).
        prod_d      = mbs_produto;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready          = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign mbs_start         = (state_q == RUN);
  assign mbs_multiplicando = op_a_q;
  assign mbs_multiplicador = op_b_q;
  assign out_valid         = out_valid_q;
  assign out_produto       = prod_q;

endmodule
